inst_encoder: RTL

Instruction encoder and loader. It takes field-level instruction descriptions (class, funct3/funct7, register indices, immediate) over a valid/ready handshake. It assembles them into 32-bit RV32I words for exactly the five opcode classes the CPU control decoder recognises, and streams them into the instruction memory write port at consecutive word addresses. It sits between the bench or boot sequencer and Instruction_Memory, so programs can be built from fields rather than hand-coded hex.

---
 rtl/inst_encoder.sv | 104 ++++++++++
 1 files changed

// File: rtl/inst_encoder.sv
// Instruction encoder/loader: packs RV32I fields into 32-bit words for the
// R, I-arith, Load, Store and Branch classes and writes them to consecutive addresses.
module inst_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 256,
    localparam int         CW        = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [2:0]    class_i,
    input  logic [2:0]    funct3_i,
    input  logic [6:0]    funct7_i,
    input  logic [4:0]    rd_i,
    input  logic [4:0]    rs1_i,
    input  logic [4:0]    rs2_i,
    input  logic [11:0]   imm_i,
    output logic          we_o,
    output logic [31:0]   addr_o,
    output logic [31:0]   data_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          err_o
);
    // Handshake: an item is consumed on a rising edge where valid_i && ready_o && !clear_i.
    // ready_o depends on count_o only; illegal classes are consumed but never written.
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic          r_we;
    logic [31:0]   r_addr;
    logic [31:0]   r_data;
    logic [31:0]   r_nxt_addr;
    logic [CW-1:0] r_count;
    logic          r_err;

    logic          w_ready;
    logic          w_legal;
    logic          w_accept;
    logic [31:0]   w_word;

    assign w_ready  = (r_count < DEPTH_C);
    assign w_legal  = (class_i <= 3'd4);
    assign w_accept = valid_i && w_ready && !clear_i;

    always_comb begin
        w_word = 32'h0;
        case (class_i)
            3'd0: w_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, 7'b0110011};
            3'd1: begin
                if (funct3_i == 3'b001 || funct3_i == 3'b101)
                    w_word = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, 7'b0010011};
                else
                    w_word = {imm_i, rs1_i, funct3_i, rd_i, 7'b0010011};
            end
            3'd2: w_word = {imm_i, rs1_i, funct3_i, rd_i, 7'b0000011};
            3'd3: w_word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], 7'b0100011};
            // imm_i holds offset[12:1], so every index here is one below the offset bit.
            3'd4: w_word = {imm_i[11], imm_i[9:4], rs2_i, rs1_i, funct3_i,
                            imm_i[3:0], imm_i[10], 7'b1100011};
            default: w_word = 32'h0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_we       <= 1'b0;
            r_addr     <= BASE_ADDR;
            r_data     <= 32'h0;
            r_nxt_addr <= BASE_ADDR;
            r_count    <= '0;
            r_err      <= 1'b0;
        end else if (clear_i) begin
            r_we       <= 1'b0;
            r_addr     <= BASE_ADDR;
            r_nxt_addr <= BASE_ADDR;
            r_count    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (w_accept) begin
                if (w_legal) begin
                    r_we       <= 1'b1;
                    r_data     <= w_word;
                    r_addr     <= r_nxt_addr;
                    r_nxt_addr <= r_nxt_addr + 32'd4;
                    r_count    <= r_count + CW'(1);
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    // A write still pending when reset arrives is suppressed in that same cycle.
    assign we_o    = r_we && !rst_i;
    assign addr_o  = r_addr;
    assign data_o  = r_data;
    assign count_o = r_count;
    assign ready_o = w_ready;
    assign full_o  = (r_count == DEPTH_C);
    assign err_o   = r_err;
endmodule
